// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the EX stage, tracking DEPTH in-flight destination tags.
// Optional statistics counters (fwd_count, stall_count) are built when FWD_STATS_EN is defined.
module fwd_hazard_unit #(
  parameter int         REG_W    = 6,
  parameter int         DEPTH    = 2,
  parameter logic [3:0] NODEP_OP = 4'b0101,
  parameter int         CNT_W    = 16,
  parameter int         SEL_W    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_op,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_pc_to_alu,
  input  logic             ex_const,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrt,
  input  logic             ex_is_load,
  input  logic             flush,
  output logic [SEL_W-1:0] mux_a,
  output logic [SEL_W-1:0] mux_b,
  output logic             stall
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] fwd_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  if (DEPTH < 2 || DEPTH > 6 || CNT_W < 1) begin : g_param_chk
    $error("fwd_hazard_unit: DEPTH must be 2..6 and CNT_W at least 1");
  end

  logic [DEPTH-1:0] tag_vld_p;
  logic [DEPTH-1:0] tag_wr_p;
  logic [REG_W-1:0] tag_rd_p [DEPTH];
  logic             tag_ld_p0;

  logic             kill;
  logic             nodep;
  logic             hit_a, hit_b;
  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic             ld_use_a, ld_use_b;

  function automatic logic tag_hit(input logic vld, input logic wr,
                                   input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
    return vld && wr && (rd != '0) && (rd == src);
  endfunction

  assign kill  = rst | flush;
  assign nodep = (ex_op == NODEP_OP);

  // Scan oldest to youngest so the youngest matching stage is the one left standing
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tag_hit(tag_vld_p[k], tag_wr_p[k], tag_rd_p[k], ex_rs)) begin
        hit_a = 1'b1;
        fwd_a = SEL_W'(k + 2);
      end
      if (tag_hit(tag_vld_p[k], tag_wr_p[k], tag_rd_p[k], ex_rt)) begin
        hit_b = 1'b1;
        fwd_b = SEL_W'(k + 2);
      end
    end
  end

  // Only a load sitting at stage 0 is too late to forward; from stage 1 on it forwards normally
  assign ld_use_a = !ex_pc_to_alu && tag_ld_p0 &&
                    tag_hit(tag_vld_p[0], tag_wr_p[0], tag_rd_p[0], ex_rs);
  assign ld_use_b = !ex_const && tag_ld_p0 &&
                    tag_hit(tag_vld_p[0], tag_wr_p[0], tag_rd_p[0], ex_rt);

  assign stall = ex_valid && !nodep && !kill && (ld_use_a || ld_use_b);

  assign mux_a = ex_pc_to_alu ? SEL_W'(1) :
                 (nodep || stall || kill || !hit_a) ? '0 : fwd_a;
  assign mux_b = ex_const ? SEL_W'(1) :
                 (nodep || stall || kill || !hit_b) ? '0 : fwd_b;

  // Tag pipeline stage boundary: a stall inserts a bubble so the held instruction meets the load at stage 1
  always_ff @(posedge clk) begin
    if (kill) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[DEPTH-2:0], ex_valid && !stall};
    end
  end

  always_ff @(posedge clk) begin
    tag_wr_p    <= {tag_wr_p[DEPTH-2:0], ex_regwrt};
    tag_ld_p0   <= ex_is_load;
    tag_rd_p[0] <= ex_rd;
    for (int k = 1; k < DEPTH; k++) begin
      tag_rd_p[k] <= tag_rd_p[k-1];
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_cyc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign fwd_cyc = !stall && (mux_a >= SEL_W'(2) || mux_b >= SEL_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fwd_cyc) fwd_count <= sat_inc(fwd_count);
      if (stall)   stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven bench for fwd_hazard_unit (DEPTH=2); each record is one EX cycle with its expected selects/stall.
// Counter checks are compiled in when FWD_STATS_EN is defined.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, ex_valid, ex_pc_to_alu, ex_const, ex_regwrt, ex_is_load, flush;
  logic [3:0] ex_op;
  logic [5:0] ex_rs, ex_rt, ex_rd;
  logic [1:0] mux_a, mux_b;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_count, stall_count;
  int          exp_fwd = 0;
  int          exp_stall = 0;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(6), .DEPTH(2), .NODEP_OP(4'b0101), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_pc_to_alu(ex_pc_to_alu), .ex_const(ex_const), .ex_rd(ex_rd), .ex_regwrt(ex_regwrt),
    .ex_is_load(ex_is_load), .flush(flush), .mux_a(mux_a), .mux_b(mux_b), .stall(stall)
`ifdef FWD_STATS_EN
    , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    int         idx;
    logic       v;
    logic [3:0] op;
    logic [5:0] rs, rt, rd;
    logic       pc, cn, wr, ld, fl, rs_t;
    logic [1:0] ea, eb;
    logic       es;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t ce;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Argument order: valid, op, rs, rt, pc_to_alu, const, rd, regwrt, load, flush, rst, exp_a, exp_b, exp_stall
  task automatic add(input logic v, input logic [3:0] op, input logic [5:0] rs, input logic [5:0] rt,
                     input logic pc, input logic cn, input logic [5:0] rd, input logic wr,
                     input logic ld, input logic fl, input logic r,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es);
    vec_t t;
    t.idx = vecs.size(); t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.pc = pc; t.cn = cn;
    t.rd = rd; t.wr = wr; t.ld = ld; t.fl = fl; t.rs_t = r; t.ea = ea; t.eb = eb; t.es = es;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    @(posedge clk);
    #1;
    rst = t.rs_t; ex_valid = t.v; ex_op = t.op; ex_rs = t.rs; ex_rt = t.rt;
    ex_pc_to_alu = t.pc; ex_const = t.cn; ex_rd = t.rd; ex_regwrt = t.wr;
    ex_is_load = t.ld; flush = t.fl;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      check("mux_a", ce.idx, int'(mux_a), int'(ce.ea));
      check("mux_b", ce.idx, int'(mux_b), int'(ce.eb));
      check("stall", ce.idx, int'(stall), int'(ce.es));
`ifdef FWD_STATS_EN
      if (ce.idx != 0) begin
        check("fwd_count", ce.idx, int'(fwd_count), exp_fwd);
        check("stall_count", ce.idx, int'(stall_count), exp_stall);
      end
      if (ce.rs_t) begin
        exp_fwd = 0;
        exp_stall = 0;
      end else begin
        if (!ce.es && (ce.ea >= 2'd2 || ce.eb >= 2'd2)) exp_fwd++;
        if (ce.es) exp_stall++;
      end
`endif
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_rs = '0; ex_rt = '0; ex_pc_to_alu = 1'b0;
    ex_const = 1'b0; ex_rd = '0; ex_regwrt = 1'b0; ex_is_load = 1'b0; flush = 1'b0;

    // reset state
    add(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0);
    add(1, 0,  0,  0, 1, 1,  0, 0, 0, 0, 1,  1, 1, 0);
    // back-to-back, then one stage older
    add(1, 0,  0,  0, 0, 0,  5, 1, 0, 0, 0,  0, 0, 0);
    add(1, 0,  5,  5, 0, 0,  0, 0, 0, 0, 0,  2, 2, 0);
    add(1, 0,  5,  5, 0, 0,  0, 0, 0, 0, 0,  3, 3, 0);
    // youngest wins, then unrelated middle instruction
    add(1, 0,  0,  0, 0, 0,  7, 1, 0, 0, 0,  0, 0, 0);
    add(1, 0,  7,  0, 0, 0,  7, 1, 0, 0, 0,  2, 0, 0);
    add(1, 0,  7,  7, 0, 0,  0, 0, 0, 0, 0,  2, 2, 0);
    add(1, 0,  7,  0, 0, 0,  0, 0, 0, 0, 0,  3, 0, 0);
    // load-use on A: one stall, then forward from stage 1
    add(1, 0,  0,  0, 0, 0,  9, 1, 1, 0, 0,  0, 0, 0);
    add(1, 0,  9,  0, 0, 0,  3, 1, 0, 0, 0,  0, 0, 1);
    add(1, 0,  9,  0, 0, 0,  3, 1, 0, 0, 0,  3, 0, 0);
    // load with immediate B: no stall
    add(1, 0,  0,  0, 0, 0,  9, 1, 1, 0, 0,  0, 0, 0);
    add(1, 0,  0,  9, 0, 1,  0, 0, 0, 0, 0,  0, 1, 0);
    add(1, 0,  0,  9, 0, 0,  0, 0, 0, 0, 0,  0, 3, 0);
    // load-use on B while A is the PC
    add(1, 0,  0,  0, 0, 0,  9, 1, 1, 0, 0,  0, 0, 0);
    add(1, 0,  9,  9, 1, 0,  0, 0, 0, 0, 0,  1, 0, 1);
    add(1, 0,  9,  9, 1, 0,  0, 0, 0, 0, 0,  1, 3, 0);
    // exemptions: rd=0, regwrt=0, NODEP opcode
    add(1, 0,  0,  0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0);
    add(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 0,  0,  0, 0, 0,  6, 0, 0, 0, 0,  0, 0, 0);
    add(1, 0,  6,  6, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 0,  0,  0, 0, 0,  8, 1, 1, 0, 0,  0, 0, 0);
    add(1, 5,  8,  8, 1, 0,  0, 0, 0, 0, 0,  1, 0, 0);
    add(1, 5,  8,  8, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    // invalid EX slot never stalls but still selects
    add(1, 0,  0,  0, 0, 0, 10, 1, 1, 0, 0,  0, 0, 0);
    add(0, 0, 10,  0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 0);
    add(1, 0, 10,  0, 0, 0,  0, 0, 0, 0, 0,  3, 0, 0);
    // flush together with a load-use hazard
    add(1, 0,  0,  0, 0, 0,  4, 1, 1, 0, 0,  0, 0, 0);
    add(1, 0,  4,  0, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0);
    add(1, 0,  4,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    // reset mid-stream
    add(1, 0,  0,  0, 0, 0, 11, 1, 0, 0, 0,  0, 0, 0);
    add(1, 0, 11, 11, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0);
    add(1, 0, 11, 11, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    // tag leaves tracking after DEPTH cycles
    add(1, 0,  0,  0, 0, 0, 12, 1, 0, 0, 0,  0, 0, 0);
    add(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 0, 12,  0, 0, 0,  0, 0, 0, 0, 0,  3, 0, 0);
    add(1, 0, 12,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", -1, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the EX stage of the CPU pipeline. It tracks the destination tags of the last DEPTH issued instructions in an internal tag pipeline that mirrors the EX/MEM, MEM/WB and later stages. Each cycle it drives the two ALU operand selects for the instruction in EX, and raises a one-cycle stall on a load-use hazard. It supersedes the combinational single-stage forwarding unit.

## Interface

Parameters:
- REG_W, 6, register address width.
- DEPTH, 2, number of tracked in-flight stages after EX. Legal range 2..6.
- NODEP_OP, 4'b0101, opcode that never forwards and never stalls (counter-increment access).
- CNT_W, 16, width of the statistics counters (used only with FWD_STATS_EN).
- SEL_W, derived as $clog2(DEPTH+2), width of the operand selects.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset, synchronous, active-high.
- ex_valid, input, 1: the EX slot holds a real instruction.
- ex_op, input, 4: opcode of the EX instruction.
- ex_rs, input, REG_W: source register of the A operand.
- ex_rt, input, REG_W: source register of the B operand.
- ex_pc_to_alu, input, 1: operand A is the PC.
- ex_const, input, 1: operand B is the immediate.
- ex_rd, input, REG_W: destination register of the EX instruction.
- ex_regwrt, input, 1: the EX instruction writes ex_rd.
- ex_is_load, input, 1: the EX instruction is a load; its result is ready one stage later.
- flush, input, 1: invalidate all tracked entries.
- mux_a, output, SEL_W: operand A select.
- mux_b, output, SEL_W: operand B select.
- stall, output, 1: hold IF/ID/EX for one cycle.
- fwd_count, output, CNT_W: number of forwarding cycles. Present only with FWD_STATS_EN.
- stall_count, output, CNT_W: number of stall cycles. Present only with FWD_STATS_EN.

## Operation

**Select encoding** (applies to both mux_a and mux_b):
- 0: register file.
- 1: PC for A, immediate for B.
- 2+k: forward from tracked stage k. Stage 0 is EX/MEM, stage 1 is MEM/WB, and so on.

**Tag pipeline**
- DEPTH entries, each holding {valid, rd, regwrt, load}.

**Match rule for stage k against source s**
- entry valid, and regwrt=1, and rd≠0, and rd==s.

**mux_a**
- ex_pc_to_alu=1 → 1.
- ex_op==NODEP_OP → 1 if ex_pc_to_alu=1, else 0.
- Otherwise the smallest matching k gives 2+k (youngest entry wins).
- No match → 0.

**mux_b**
- Same as mux_a, using ex_const and ex_rt.

**stall**
- Asserted when ex_valid=1, ex_op≠NODEP_OP, and stage 0 matches a used source (A used when ex_pc_to_alu=0, B used when ex_const=0) with load=1.
- While stall is asserted, both selects take their non-forwarding value: 1 if PC/immediate, else 0.

**Pipeline update** (every clock edge)
- Entries 1..DEPTH-1 take the previous entry.
- Entry 0 takes {ex_valid, ex_rd, ex_regwrt, ex_is_load} when stall=0.
- Entry 0 takes a bubble (valid=0) when stall=1. The held instruction re-presents next cycle and finds the load at stage 1, so it forwards with select 3.

**Reset and flush**
- rst or flush clears every entry to valid=0.
- Simultaneous flush and stall: flush wins, and stall is forced to 0 in that cycle.
- While rst=1: stall=0, and the selects take their non-forwarding value.

## Timing
- mux_a, mux_b and stall are combinational from the ex_* inputs and the registered tag pipeline. Zero-cycle latency.
- An instruction's tag is visible at stage 0 one cycle after it sits in EX, and at stage k after k+1 cycles.
- A load-use hazard costs exactly one stall cycle, for any DEPTH.
- Tags leave tracking after DEPTH cycles. The register file must supply the value by then.
- Reset is synchronous. The pipeline is empty on the first edge with rst=1, and rst asserted mid-operation discards all in-flight tags.

## Configuration
- FWD_STATS_EN defined: fwd_count and stall_count exist. Both reset to 0 on rst and are unaffected by flush.
  - fwd_count increments by 1 in each cycle with stall=0 where mux_a≥2 or mux_b≥2.
  - stall_count increments in each cycle with stall=1.
  - Both saturate at all-ones.
- FWD_STATS_EN undefined: neither the counter ports nor the counter logic exist. Select and stall behaviour is identical in both builds.

## Test plan
- Back-to-back dependency: issue rd=5 (regwrt=1, load=0), then rs=5, rt=5 next cycle → mux_a=2, mux_b=2, stall=0.
- Two-back dependency with a younger conflict: rd=7, then rd=7, then rs=7 → mux_a=2 (youngest wins). With an unrelated middle instruction instead → mux_a=3.
- Load-use: load rd=9, then rs=9 → stall=1 for exactly one cycle. Next cycle mux_a=3, stall=0. With ex_const=1 and rt=9 only → no stall.
- Exemptions: rd=0 with regwrt=1, or regwrt=0, or ex_op=4'b0101 with a matching rs → mux_a=ex_pc_to_alu, stall=0.
- Flush and reset: load rd=4, then assert flush together with a dependent rs=4 → stall=0, mux_a=0. Pulse rst mid-stream → next dependent instruction gets mux_a=0.
- FWD_STATS_EN: 3 forwarding cycles plus 1 stall → fwd_count=3, stall_count=1. With CNT_W=2 and 5 forwards → fwd_count holds at 3.
